// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: walks the frame in raster order and hands each coordinate to
// an idle Mandelbrot engine via round-robin arbitration, one grant per cycle.
module pixel_dispatcher #(
  parameter int NUM_ENGINES      = 12,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int X_SIZE           = 640,
  parameter int Y_SIZE           = 480
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        restart,
  input  logic                        hold,
  input  logic [NUM_ENGINES-1:0]      eng_req,
  output logic [NUM_ENGINES-1:0]      eng_grant,
  output logic [PIXEL_DATA_WIDTH-1:0] x_o,
  output logic [PIXEL_DATA_WIDTH-1:0] y_o,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FLUSH} state_t;

  state_t                      state_q;
  logic [PIXEL_DATA_WIDTH-1:0] xCnt_q, yCnt_q;
  logic [PIXEL_DATA_WIDTH-1:0] xOut_q, yOut_q;
  logic [IDX_W-1:0]            rrPtr_q, rrPtr_d;
  logic [NUM_ENGINES-1:0]      grant_q;
  logic                        busy_q, frameDone_q;

  logic [NUM_ENGINES-1:0] eligible;
  logic                   allReq;
  logic                   pickValid;
  logic [IDX_W-1:0]       pickIdx;
  logic [IDX_W-1:0]       candIdx;
  int                     idx;
  logic                   xLast, yLast;

  // Engines drop req one cycle after their grant, so last cycle's winner is masked.
  always_comb begin
    eligible  = eng_req & ~grant_q;
    allReq    = &eng_req;
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      idx = int'(rrPtr_q) + i;
      if (idx >= NUM_ENGINES) idx = idx - NUM_ENGINES;
      candIdx = IDX_W'(idx);
      if (!pickValid && eligible[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
    rrPtr_d = (pickIdx == IDX_W'(NUM_ENGINES - 1)) ? '0 : pickIdx + 1'b1;
    xLast   = (xCnt_q == PIXEL_DATA_WIDTH'(X_SIZE - 1));
    yLast   = (yCnt_q == PIXEL_DATA_WIDTH'(Y_SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      xCnt_q      <= '0;
      yCnt_q      <= '0;
      xOut_q      <= '0;
      yOut_q      <= '0;
      rrPtr_q     <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      grant_q     <= '0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || restart) begin
            state_q <= DISPATCH;
            xCnt_q  <= '0;
            yCnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        DISPATCH: begin
          // A restart wins over any grant that would have been issued this cycle.
          if (restart) begin
            state_q <= FLUSH;
          end else if (!hold && pickValid) begin
            grant_q <= NUM_ENGINES'(1) << pickIdx;
            xOut_q  <= xCnt_q;
            yOut_q  <= yCnt_q;
            rrPtr_q <= rrPtr_d;
            if (xLast && yLast) begin
              state_q <= DRAIN;
            end else if (xLast) begin
              xCnt_q <= '0;
              yCnt_q <= yCnt_q + 1'b1;
            end else begin
              xCnt_q <= xCnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (restart) begin
            state_q <= FLUSH;
          end else if (allReq && (grant_q == '0)) begin
            frameDone_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        FLUSH: begin
          // Wait for every engine to abandon its stale pixel before re-rendering.
          if (allReq) begin
            state_q <= DISPATCH;
            xCnt_q  <= '0;
            yCnt_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng_grant  = grant_q;
  assign x_o        = xOut_q;
  assign y_o        = yOut_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
- On-demand work scheduler for the Mandelbrot engine array. Replaces lockstep distribution, where every engine is handed a new pixel only when all engines finish.
- Walks the frame in raster order and hands the next pixel coordinate to any idle engine via round-robin arbitration, one grant per cycle.
- Supports stall from full colour queues and a restart when zoom or offset change mid-frame.
- Sits between the frame control logic and the mandelbrot_engine instances.

Parameters:
NUM_ENGINES, 12, number of engine requesters
PIXEL_DATA_WIDTH, 10, width of x/y pixel coordinates
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  frame start pulse; honoured only in IDLE
restart  input  1  view parameters changed; abort current frame and re-render from (0,0)
hold  input  1  stall; no grant is issued while high (downstream queue full)
eng_req  input  NUM_ENGINES  bit i high = engine i idle and requesting a pixel
eng_grant  output  NUM_ENGINES  registered one-hot grant, valid for one cycle
x_o  output  PIXEL_DATA_WIDTH  x coordinate for the granted engine; valid when eng_grant!=0
y_o  output  PIXEL_DATA_WIDTH  y coordinate for the granted engine; valid when eng_grant!=0
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse when the last pixel of a completed frame has been computed

Behaviour:
- Reset state: state=IDLE, eng_grant=0, x_o=0, y_o=0, busy=0, frame_done=0, x/y counters=0, rr pointer=0 (engine 0 highest priority).
- Reset overrides every other input in the same cycle.
- All outputs are registered.
- States: IDLE, DISPATCH, DRAIN, FLUSH.
- IDLE:
  - start or restart high → DISPATCH, counters cleared to (0,0).
  - Otherwise stay; eng_grant=0.
- DISPATCH:
  - Each cycle with hold=0 and a nonzero eligible request set, grant one engine.
  - Eligible = eng_req with the bit granted in the previous cycle masked off. Engines deassert req one cycle after grant, so this prevents a double grant.
  - Round-robin: search starts at rr pointer, wrapping from NUM_ENGINES-1 to 0. After a grant to engine k, rr pointer = k+1 mod NUM_ENGINES.
  - With a grant, x_o/y_o are driven with the current counter values in the same registered cycle.
  - Counter advance: x++. If x==X_SIZE-1 then x=0, y++.
  - Grant of (X_SIZE-1, Y_SIZE-1) → DRAIN next cycle; counters hold.
  - hold=1 or no eligible request: eng_grant=0, counters and pointer unchanged. x_o/y_o keep their last values.
- DRAIN:
  - No grants.
  - When eng_req == all ones (and no grant in the previous cycle), pulse frame_done for 1 cycle and go to IDLE.
- restart while in DISPATCH or DRAIN:
  - → FLUSH immediately; a grant computed in that cycle is suppressed.
  - FLUSH issues no grants and waits for eng_req == all ones, then → DISPATCH with counters (0,0). rr pointer is kept.
  - No frame_done for an aborted frame.
  - restart in FLUSH is absorbed, with no extra effect.
- start outside IDLE is ignored.
- start and restart together in IDLE act as a single start.
- Latency:
  - start sampled at edge t → busy=1 from t+1.
  - First eng_grant is possible at edge t+2.
  - Thereafter at most one grant per cycle: full throughput 1 pixel/cycle.
- hold has a 1-cycle effect: hold high at edge t → no grant register update at edge t+1.
- Widths: counters PIXEL_DATA_WIDTH bits. X_SIZE and Y_SIZE must be ≤ 2^PIXEL_DATA_WIDTH; the counters never exceed SIZE-1.
- Invariant: $onehot0(eng_grant) every cycle.

Test Plan:
- X_SIZE=4, Y_SIZE=2, NUM_ENGINES=3, all eng_req high, start pulse:
  - grants go to engines 0,1,2,0,1,2,0,1 with coordinates (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1) on consecutive cycles after the first cycle's mask rule is satisfied.
  - frame_done pulses once after all req return high; busy then falls.
- Only engine 1 requests, with a 3-cycle busy period after each grant:
  - every grant goes to engine 1.
  - no back-to-back grant; gaps equal the engine's busy time.
- hold high for 5 cycles mid-frame:
  - eng_grant=0 for those cycles.
  - next grant resumes at the exact next coordinate, with no skip and no repeat.
- restart at pixel (2,0), with engine 2 still busy:
  - FLUSH, with no grants until engine 2 requests again.
  - then a grant with (0,0).
  - no frame_done for the aborted frame.
- reset asserted in DISPATCH at pixel (1,1):
  - next cycle all outputs 0, state IDLE.
  - a subsequent start begins at (0,0) with engine 0.
- Scoreboard over a full 640x480 run with random eng_req and hold:
  - every coordinate issued exactly once, in raster order.
  - $onehot0 holds every cycle.
  - frame_done pulses exactly once.
